// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers.
// One shift-add or restoring-subtract step per cycle; busy stalls the X stage.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             kill,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               div_q, neg_q, rs_neg_q, dz_q;
   logic [WIDTH-1:0]   a_q, rs_raw_q;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, dbz_q, dbz_d, busy_q;

   logic               accept_s, rs_sgn_s, rt_sgn_s;
   logic [WIDTH-1:0]   rs_mag_s, rt_mag_s;
   logic [WIDTH:0]     mul_sum_s, div_rem_s, div_diff_s;
   logic [2*WIDTH-1:0] prod_s;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   assign accept_s = (state_q == S_IDLE) && start && !kill;
   assign rs_sgn_s = op[0] & rs[WIDTH-1];
   assign rt_sgn_s = op[0] & rt[WIDTH-1];
   assign rs_mag_s = mag(rs, rs_sgn_s);
   assign rt_mag_s = mag(rt, rt_sgn_s);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   // Next-state logic; kill returns to IDLE from any active state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = S_RUN;
            else          state_d = S_IDLE;
         end
         S_RUN: begin
            if (kill)                             state_d = S_IDLE;
            else if (cnt_q == CW'(WIDTH - 1))     state_d = S_FIX;
            else                                  state_d = S_RUN;
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // One iteration: multiply adds into the upper half then shifts right,
   // divide shifts left and keeps the trial difference when non-negative
   always_comb begin
      mul_sum_s  = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
      div_rem_s  = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff_s = div_rem_s - {1'b0, a_q};
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      if (state_q == S_RUN) begin
         cnt_d = cnt_q + CW'(1);
         if (div_q) begin
            if (div_diff_s[WIDTH]) acc_d = {1'b0, div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else                   acc_d = {1'b0, div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {1'b0, mul_sum_s, acc_q[WIDTH-1:1]};
         end
      end else if (accept_s) begin
         cnt_d = {CW{1'b0}};
         acc_d = {{(WIDTH+1){1'b0}}, (op[1] ? rs_mag_s : rt_mag_s)};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Datapath and operand latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= {CW{1'b0}};
         acc_q    <= {(2*WIDTH+1){1'b0}};
         a_q      <= {WIDTH{1'b0}};
         rs_raw_q <= {WIDTH{1'b0}};
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         rs_neg_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         if (accept_s) begin
            a_q      <= op[1] ? rt_mag_s : rs_mag_s;
            rs_raw_q <= rs;
            div_q    <= op[1];
            neg_q    <= rs_sgn_s ^ rt_sgn_s;
            rs_neg_q <= rs_sgn_s;
            dz_q     <= (rt == {WIDTH{1'b0}});
         end
      end
   end

   // Result/output logic: FIX commits the result, IDLE accepts MTHI/MTLO
   always_comb begin
      prod_s = neg_q ? (~acc_q[2*WIDTH-1:0] + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q[2*WIDTH-1:0];
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      dbz_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!accept_s) begin
               if (hi_we) hi_d = wdata;
               else       hi_d = hi_q;
               if (lo_we) lo_d = wdata;
               else       lo_d = lo_q;
            end else begin
               hi_d = hi_q;
            end
         end
         S_FIX: begin
            if (kill) begin
               done_d = 1'b0;
            end else if (!div_q) begin
               done_d = 1'b1;
               hi_d   = prod_s[2*WIDTH-1:WIDTH];
               lo_d   = prod_s[WIDTH-1:0];
            end else if (dz_q) begin
               done_d = 1'b1;
               dbz_d  = 1'b1;
               hi_d   = rs_raw_q;
               lo_d   = {WIDTH{1'b1}};
            end else begin
               done_d = 1'b1;
               lo_d   = mag(acc_q[WIDTH-1:0], neg_q);
               hi_d   = mag(acc_q[2*WIDTH-1:WIDTH], rs_neg_q);
            end
         end
         default: begin
            hi_d = hi_q;
         end
      endcase
   end

   // Result registers and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= {WIDTH{1'b0}};
         lo_q   <= {WIDTH{1'b0}};
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
         dbz_q  <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed vectors, immediate assertions.
module tb_muldiv_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] rs = '0, rt = '0, wdata = '0;
   logic         kill = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int nbusy;
   logic seen_done;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
      .kill(kill), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive a start for one cycle; returns at the negedge after the acceptance edge
   task automatic go(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      op = o; rs = a; rt = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic watch_no_done(input int cycles, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
   endtask

   initial begin
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_dbz", div_by_zero, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // MULTU max*max
      go(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(nbusy);
      chk("multu_busy_cycles", nbusy, 33);
      chk("multu_done", done, 1'b1);
      chk("multu_hi", hi, 32'hFFFFFFFE);
      chk("multu_lo", lo, 32'h00000001);
      chk("multu_dbz", div_by_zero, 1'b0);
      @(negedge clk);
      chk("multu_done_fall", done, 1'b0);

      // MULT -3*7 then back-to-back DIV -7/2 in the done cycle
      go(2'b01, 32'hFFFFFFFD, 32'd7);
      wait_done(nbusy);
      chk("mult_busy_cycles", nbusy, 33);
      chk("mult_done", done, 1'b1);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFEB);
      go(2'b11, 32'hFFFFFFF9, 32'd2);
      chk("b2b_busy", busy, 1'b1);
      wait_done(nbusy);
      chk("div_busy_cycles", nbusy, 33);
      chk("div_done", done, 1'b1);
      chk("div_lo", lo, 32'hFFFFFFFD);
      chk("div_hi", hi, 32'hFFFFFFFF);
      @(negedge clk);

      // DIVU by zero, then DIVU 100/7
      go(2'b10, 32'd100, 32'd0);
      wait_done(nbusy);
      chk("dz_busy_cycles", nbusy, 33);
      chk("dz_done", done, 1'b1);
      chk("dz_flag", div_by_zero, 1'b1);
      chk("dz_hi", hi, 32'h64);
      chk("dz_lo", lo, 32'hFFFFFFFF);
      @(negedge clk);
      chk("dz_flag_fall", div_by_zero, 1'b0);
      go(2'b10, 32'd100, 32'd7);
      wait_done(nbusy);
      chk("divu_done", done, 1'b1);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      chk("divu_dbz", div_by_zero, 1'b0);
      @(negedge clk);

      // Preload HI/LO, then kill a MULTU at busy cycle 10
      hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mthi", hi, 32'h1234);
      chk("mtlo", lo, 32'h5678);
      go(2'b00, 32'd5, 32'd6);
      repeat (4) @(negedge clk);
      hi_we = 1'b1; wdata = 32'hDEAD;
      @(negedge clk);
      hi_we = 1'b0;
      chk("busy_write_dropped", hi, 32'h1234);
      repeat (4) @(negedge clk);
      chk("kill_pre_busy", busy, 1'b1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_busy", busy, 1'b0);
      chk("kill_done", done, 1'b0);
      watch_no_done(40, seen_done);
      chk("kill_no_done", seen_done, 1'b0);
      chk("kill_hi", hi, 32'h1234);
      chk("kill_lo", lo, 32'h5678);

      // kill in IDLE cancels a same-cycle start
      op = 2'b00; rs = 32'd2; rt = 32'd2; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("idle_kill_busy", busy, 1'b0);

      // Signed overflow min_int / -1
      go(2'b11, 32'h80000000, 32'hFFFFFFFF);
      wait_done(nbusy);
      chk("ovf_done", done, 1'b1);
      chk("ovf_lo", lo, 32'h80000000);
      chk("ovf_hi", hi, 32'h0);
      chk("ovf_dbz", div_by_zero, 1'b0);
      @(negedge clk);

      // hi_we coincident with an accepted start is dropped
      hi_we = 1'b1; wdata = 32'hAAAA;
      @(negedge clk);
      wdata = 32'hBBBB;
      go(2'b00, 32'd3, 32'd3);
      hi_we = 1'b0;
      chk("start_write_dropped", hi, 32'hAAAA);
      wait_done(nbusy);
      chk("mul33_hi", hi, 32'd0);
      chk("mul33_lo", lo, 32'd9);
      @(negedge clk);

      // Preload nonzero HI/LO, then async reset at busy cycle 20
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      go(2'b00, 32'd3, 32'd3);
      repeat (19) @(negedge clk);
      chk("rstmid_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_hi", hi, 32'h0);
      chk("rstmid_lo", lo, 32'h0);
      chk("rstmid_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_done(40, seen_done);
      chk("rstmid_no_done", seen_done, 1'b0);
      chk("rstmid_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
